// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and lives-bus defaults,
// so producers and consumers of lives/game_over decode them identically.
package game_pkg;

    // Lives-bus defaults
    localparam int LIVES_W_DEF     = 3;
    localparam int START_LIVES_DEF = 3;
    localparam int MAX_LIVES_DEF   = 7;

    // Player-life FSM encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_INVULN  = 2'd2,
        ST_DEAD    = 2'd3
    } life_state_t;

endpackage

// File: rtl/invuln_timer.sv
// Loadable down-counter for the post-hit grace window.
// Ports: clk, rst (sync, active-high), load (preset to LOAD_VAL),
//        en (count down, stops at zero), done (count == 0).
module invuln_timer #(
    parameter int TMR_W    = 26,
    parameter int LOAD_VAL = 49999999
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [TMR_W-1:0] LOAD = TMR_W'(LOAD_VAL);
    localparam logic [TMR_W-1:0] ONE  = TMR_W'(1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD;
        end else if (en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/life_tracker.sv
// Player life counter: turns start/hit/bonus pulses into a saturating
// life count with a post-hit grace window and a game-over flag.
// Ports: clk, rst (sync, active-high), start, hit, bonus (1-cycle
//        pulses); lives, invuln, life_lost, game_over (registered).
// Build option: define LIFE_BONUS_EN to enable bonus lives; otherwise
//        the bonus input is ignored and lives only decrease.
module life_tracker
    import game_pkg::*;
#(
    parameter int LIVES_W       = LIVES_W_DEF,
    parameter int START_LIVES   = START_LIVES_DEF,
    parameter int MAX_LIVES     = MAX_LIVES_DEF,
    parameter int INVULN_CYCLES = 50000000,
    parameter int TMR_W         = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic               bonus,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic               life_lost,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] START_L = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] ONE     = LIVES_W'(1);

    life_state_t state;

    logic               bonus_act;
    logic [LIVES_W-1:0] lives_inc;

`ifdef LIFE_BONUS_EN
    localparam logic [LIVES_W-1:0] MAX_L = LIVES_W'(MAX_LIVES);

    assign bonus_act = bonus;
    assign lives_inc = (lives >= MAX_L) ? lives : lives + ONE;
`else
    logic unused_bonus;

    assign unused_bonus = bonus;
    assign bonus_act    = 1'b0;
    assign lives_inc    = lives;
`endif

    logic hit_ok;
    logic last_life;
    logic go_invuln;
    logic tmr_done;

    // A same-cycle bonus cancels the loss, so the last life survives.
    assign hit_ok    = (state == ST_PLAYING) && hit;
    assign last_life = (lives == ONE) && !bonus_act;
    assign go_invuln = hit_ok && !last_life;

    invuln_timer #(
        .TMR_W    (TMR_W),
        .LOAD_VAL (INVULN_CYCLES - 1)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (go_invuln),
        .en   (state == ST_INVULN),
        .done (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lives     <= START_L;
            invuln    <= 1'b0;
            life_lost <= 1'b0;
            game_over <= 1'b0;
        end else begin
            life_lost <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DEAD: begin
                    if (start) begin
                        state     <= ST_PLAYING;
                        lives     <= START_L;
                        invuln    <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    if (hit) begin
                        life_lost <= 1'b1;
                        if (bonus_act) begin
                            state  <= ST_INVULN;
                            invuln <= 1'b1;
                        end else if (lives == ONE) begin
                            lives     <= '0;
                            state     <= ST_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            lives  <= lives - ONE;
                            state  <= ST_INVULN;
                            invuln <= 1'b1;
                        end
                    end else if (bonus_act) begin
                        lives <= lives_inc;
                    end
                end
                ST_INVULN: begin
                    if (bonus_act) begin
                        lives <= lives_inc;
                    end
                    if (tmr_done) begin
                        state  <= ST_PLAYING;
                        invuln <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_tracker.sv
// Directed bench for life_tracker with a 4-cycle grace window.
// Bonus expectations follow the LIFE_BONUS_EN build option.
module tb_life_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       bonus = 1'b0;
    logic [2:0] lives;
    logic       invuln;
    logic       life_lost;
    logic       game_over;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    life_tracker #(
        .LIVES_W       (3),
        .START_LIVES   (3),
        .MAX_LIVES     (7),
        .INVULN_CYCLES (4),
        .TMR_W         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hit       (hit),
        .bonus     (bonus),
        .lives     (lives),
        .invuln    (invuln),
        .life_lost (life_lost),
        .game_over (game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic h, input logic b);
        start = s;
        hit   = h;
        bonus = b;
        step();
        start = 1'b0;
        hit   = 1'b0;
        bonus = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int l, input int inv,
                           input int ll, input int go);
        chk({tag, ".lives"}, int'(lives), l);
        chk({tag, ".invuln"}, int'(invuln), inv);
        chk({tag, ".life_lost"}, int'(life_lost), ll);
        chk({tag, ".game_over"}, int'(game_over), go);
    endtask

    task automatic wait_window();
        repeat (4) step();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 3, 0, 0, 0);

        // Hit in IDLE is ignored
        pulse(0, 1, 0);
        chk_all("idle_hit", 3, 0, 0, 0);

        // Start
        pulse(1, 0, 0);
        chk_all("start", 3, 0, 0, 0);

        // First hit: window cycle 1
        pulse(0, 1, 0);
        chk_all("hit1", 2, 1, 1, 0);
        step();
        chk_all("win2", 2, 1, 0, 0);
        // Hit during window ignored (cycle 3)
        pulse(0, 1, 0);
        chk_all("win3_hit", 2, 1, 0, 0);
        step();
        chk("win4.invuln", int'(invuln), 1);
        step();
        chk("win_end.invuln", int'(invuln), 0);
        // Hit right after window falls is accepted
        pulse(0, 1, 0);
        chk_all("hit2", 1, 1, 1, 0);
        wait_window();
        chk("win2_end.invuln", int'(invuln), 0);

        // Start mid-game ignored
        pulse(1, 0, 0);
        chk_all("midgame_start", 1, 0, 0, 0);

        // Last life
        pulse(0, 1, 0);
        chk_all("hit3_dead", 0, 0, 1, 1);
        pulse(0, 1, 0);
        chk_all("dead_hit", 0, 0, 0, 1);
        pulse(0, 0, 1);
        chk_all("dead_bonus", 0, 0, 0, 1);
        pulse(1, 0, 0);
        chk_all("restart", 3, 0, 0, 0);

        // Bonus pickups
        for (int i = 0; i < 5; i++) begin
            int exp_l;
`ifdef LIFE_BONUS_EN
            exp_l = (3 + i + 1 > 7) ? 7 : 3 + i + 1;
`else
            exp_l = 3;
`endif
            pulse(0, 0, 1);
            chk($sformatf("bonus%0d.lives", i), int'(lives), exp_l);
        end

        // Fresh game down to one life
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        wait_window();
        pulse(0, 1, 0);
        chk("to_one.lives", int'(lives), 1);
        wait_window();

        // Hit and bonus together at one life
        pulse(0, 1, 1);
`ifdef LIFE_BONUS_EN
        chk_all("hit_bonus", 1, 1, 1, 0);
`else
        chk_all("hit_bonus", 0, 0, 1, 1);
`endif

        // Reset during the third window cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("rw_c1.invuln", int'(invuln), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_mid", 3, 0, 0, 0);
        pulse(0, 1, 0);
        chk_all("rst_idle_hit", 3, 0, 0, 0);

        // Reset squashes a hit on the same edge
        pulse(1, 0, 0);
        rst = 1'b1;
        hit = 1'b1;
        step();
        rst = 1'b0;
        hit = 1'b0;
        chk_all("rst_hit", 3, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
